// File: rtl/shift_rx_pkg.sv
// rtl/shift_rx_pkg.sv - shared types and constants for the shift_rx serial receiver
//
// Purpose : receiver FSM state type and the default data width.
// Contents: rx_state_t (IDLE, SHIFT, PARITY), DEFAULT_WIDTH.

package shift_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } rx_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shift_rx_hold.sv
// rtl/shift_rx_hold.sv - one-entry valid/ready output buffer for shift_rx
//
// Purpose : holds the most recent completed word until the consumer takes it;
//           a completion that finds the buffer full (and not being drained in
//           the same cycle) is dropped and reported with a one-cycle ovf pulse.
// Ports   : ck, rst (async, active-high), clr (sync flush)
//           done_i, word_i  - completion strobe and assembled word
//           q_rdy_i         - consumer accept
//           q_o, q_vld_o    - buffered word and its valid flag
//           ovf_o           - registered drop pulse

module shift_rx_hold
  import shift_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             clr,
  input  logic             done_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             q_rdy_i,
  output logic [WIDTH-1:0] q_o,
  output logic             q_vld_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    q_d   = q_q;
    vld_d = vld_q;
    ovf_d = 1'b0;
    if (clr) begin
      vld_d = 1'b0;
    end else if (done_i) begin
      // An accept in the same cycle frees the slot for the new word.
      if (!vld_q || q_rdy_i) begin
        q_d   = word_i;
        vld_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (vld_q && q_rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      q_q   <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      vld_q <= vld_d;
      ovf_q <= ovf_d;
    end
  end

  assign q_o     = q_q;
  assign q_vld_o = vld_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/shift_rx.sv
// rtl/shift_rx.sv - MSB-first serial-to-parallel receiver with optional even parity
//
// Purpose : collects WIDTH qualified bits (first bit = MSB) into a word and
//           hands it to a one-entry valid/ready buffer. Build option
//           PARITY_EN adds a trailing even-parity bit per frame and par_err.
// Ports   : ck, rst (async, active-high), clr (sync clear, highest priority)
//           sin, sin_vld, sin_sof - serial bit, qualifier, start of frame
//           q, q_vld, q_rdy       - word output handshake
//           ovf, frm_err, par_err - registered one-cycle error pulses

module shift_rx
  import shift_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             sin_sof,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  input  logic             q_rdy,
  output logic             ovf,
  output logic             frm_err,
  output logic             par_err
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  rx_state_t        state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frm_err_q, frm_err_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             done;

`ifdef PARITY_EN
  logic par_q, par_d;
  logic par_bad;
  logic par_err_q;
`endif

  assign shifted = {sr_q[WIDTH-2:0], sin};

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    frm_err_d = 1'b0;
    done      = 1'b0;
    word      = sr_q;
`ifdef PARITY_EN
    par_d     = par_q;
    par_bad   = 1'b0;
`endif
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (sin_vld) begin
      if (sin_sof) begin
        // A start bit always begins a fresh frame; mid-frame it also flags.
        frm_err_d = (state_q != IDLE);
        sr_d      = shifted;
        cnt_d     = CW'(1);
        state_d   = SHIFT;
`ifdef PARITY_EN
        par_d     = sin;
`endif
      end else begin
        case (state_q)
          SHIFT: begin
            sr_d  = shifted;
            cnt_d = cnt_q + CW'(1);
`ifdef PARITY_EN
            par_d = par_q ^ sin;
            if (cnt_q == LAST) state_d = PARITY;
`else
            if (cnt_q == LAST) begin
              state_d = IDLE;
              done    = 1'b1;
              word    = shifted;
            end
`endif
          end
`ifdef PARITY_EN
          PARITY: begin
            state_d = IDLE;
            done    = 1'b1;
            word    = sr_q;
            par_bad = par_q ^ sin;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      frm_err_q <= frm_err_d;
    end
  end

`ifdef PARITY_EN
  // Parity is only reported for a word the buffer actually takes.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      par_q     <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      par_err_q <= done && (!q_vld || q_rdy) && par_bad;
    end
  end
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign frm_err = frm_err_q;

  shift_rx_hold #(.WIDTH(WIDTH)) u_hold (
    .ck      (ck),
    .rst     (rst),
    .clr     (clr),
    .done_i  (done),
    .word_i  (word),
    .q_rdy_i (q_rdy),
    .q_o     (q),
    .q_vld_o (q_vld),
    .ovf_o   (ovf)
  );

endmodule
